mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a byte-addressed, big-endian word memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  // A word occupies addr and addr+1, so the last legal word address is one below the final byte.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic                  grant_id;
  logic                  load;
  logic                  capture;
  logic                  finish;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  id_q;
  logic                  wr_q;
  logic                  oor_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  always_comb begin
    if (req0 && req1) grant_id = ~last_grant;
    else              grant_id = req1;
  end

  // Starts at requester 1 so requester 0 takes the first tie after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     last_grant <= 1'b1;
    else if (load) last_grant <= grant_id;
  end
`else
  always_comb begin
    grant_id = req1 & ~req0;
  end
`endif

  always_comb begin
    sel_wr    = grant_id ? wr1    : wr0;
    sel_addr  = grant_id ? addr1  : addr0;
    sel_wdata = grant_id ? wdata1 : wdata0;
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          load       = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        capture    = ~wr_q & ~oor_q;
        state_next = DONE;
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the command and data registers are reset too, because mem_address, mem_data_in and rdata must read 0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (load) begin
        id_q    <= grant_id;
        wr_q    <= sel_wr;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        oor_q   <= (sel_addr > LAST_ADDR);
      end
      if (capture) rdata <= mem_data_out;
      // The ack registers out of DONE, so it is seen in the cycle after DONE.
      ack0 <= finish & ~id_q;
      ack1 <= finish &  id_q;
      err  <= finish &  oor_q;
    end
  end

  // mem_wr_en decodes from the state register, so an asynchronous reset removes it at once.
  always_comb begin
    mem_address = addr_q;
    mem_data_in = wdata_q;
    mem_wr_en   = (state == ACCESS) & wr_q & ~oor_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte-wide big-endian memory model.
module tb_mem_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] EXP_ORDER = 4'b1010;
`else
  localparam logic [3:0] EXP_ORDER = 4'b0000;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, err;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_address;
  logic          mem_wr_en;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  int checks   = 0;
  int failures = 0;
  int wr_cnt   = 0;

  logic [7:0] mem [0:DEPTH-1];

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // Memory model: big-endian word, high byte at the addressed location.
  always @(posedge clock) begin
    if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(mem_address) <= DEPTH - 2) begin
        mem[mem_address[9:0]]         <= mem_data_in[15:8];
        mem[mem_address[9:0] + 10'd1] <= mem_data_in[7:0];
      end
    end
  end

  always_comb begin
    if (int'(mem_address) <= DEPTH - 2)
      mem_data_out = {mem[mem_address[9:0]], mem[mem_address[9:0] + 10'd1]};
    else
      mem_data_out = 16'hBEEF;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One access from a single requester; returns after the ack cycle plus one idle cycle.
  task automatic run(input string tag, input bit id, input bit w, input logic [15:0] a,
                     input logic [15:0] d, input bit exp_err, input bit chk_rd,
                     input logic [15:0] exp_rd);
    int          lat;
    int          w0;
    logic        e;
    logic [15:0] rd;
    bit          other;
    w0 = wr_cnt; lat = 0; e = 1'b0; rd = '0; other = 1'b0;
    if (id) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    else    begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
    while (lat < 12) begin
      @(negedge clock);
      lat++;
      if (id ? ack0 : ack1) other = 1'b1;
      if (id ? ack1 : ack0) begin
        e  = err;
        rd = rdata;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check($sformatf("%s latency", tag), lat, 3);
    check($sformatf("%s err", tag), e, exp_err);
    check($sformatf("%s other_ack", tag), other, 0);
    check($sformatf("%s mem_wr_en cycles", tag), wr_cnt - w0, (w && !exp_err) ? 1 : 0);
    if (chk_rd) check($sformatf("%s rdata", tag), rd, exp_rd);
    @(negedge clock);
    check($sformatf("%s post ack/err", tag), {ack0, ack1, err}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          n;
    int          last;
    int          w0;
    bit          seen;
    logic [3:0]  order;

    reset = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(negedge clock);
    check("reset ack/err/wr_en", {ack0, ack1, err, mem_wr_en}, 0);
    check("reset rdata", rdata, 0);
    check("reset mem_address", mem_address, 0);
    check("reset mem_data_in", mem_data_in, 0);
    reset = 1'b0;
    @(negedge clock);

    // Write then read back.
    run("wr 0004", 0, 1, 16'h0004, 16'hA55A, 0, 0, 16'h0000);
    check("mem 0004/0005", {mem[4], mem[5]}, 16'hA55A);
    run("rd 0004", 0, 0, 16'h0004, 16'h0000, 0, 1, 16'hA55A);
    check("mem_address holds", mem_address, 16'h0004);

    // Odd address via requester 1.
    run("wr 0007", 1, 1, 16'h0007, 16'h1357, 0, 0, 16'h0000);
    check("mem 0007", mem[7], 8'h13);
    run("rd 0007", 1, 0, 16'h0007, 16'h0000, 0, 1, 16'h1357);

    // Range boundary.
    run("wr 1022", 0, 1, 16'd1022, 16'hC3D4, 0, 0, 16'h0000);
    run("wr 1023", 0, 1, 16'd1023, 16'h1111, 1, 0, 16'h0000);
    run("wr FFFF", 1, 1, 16'hFFFF, 16'h2222, 1, 0, 16'h0000);
    check("mem 1022/1023 intact", {mem[1022], mem[1023]}, 16'hC3D4);
    run("rd 1022", 0, 0, 16'd1022, 16'h0000, 0, 1, 16'hC3D4);
    run("rd 1023 keeps rdata", 0, 0, 16'd1023, 16'h0000, 1, 1, 16'hC3D4);

    // Back-to-back reads from requester 1.
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0007;
    cyc = 0; n = 0; last = 0; seen = 1'b0;
    while (n < 3 && cyc < 30) begin
      @(negedge clock);
      cyc++;
      if (ack0) seen = 1'b1;
      if (ack1) begin
        check("b2b rdata", rdata, 16'h1357);
        if (n == 0) check("b2b first latency", cyc, 3);
        else        check("b2b ack spacing", cyc - last, 3);
        last = cyc;
        n++;
        if (n == 3) req1 = 1'b0;
      end
    end
    req1 = 1'b0;
    check("b2b ack1 count", n, 3);
    check("b2b no ack0", seen, 0);

    // Simultaneous requests held for four accesses.
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0004;
    req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0007;
    cyc = 0; n = 0; last = 0; seen = 1'b0; order = '0;
    while (n < 4 && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (ack0 && ack1) seen = 1'b1;
      if (ack0 || ack1) begin
        order[n] = ack1;
        check("tie rdata", rdata, ack1 ? 16'h1357 : 16'hA55A);
        if (n > 0) check("tie ack spacing", cyc - last, 3);
        last = cyc;
        n++;
        if (n == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie ack count", n, 4);
    check("tie grant order", order, EXP_ORDER);
    check("tie no double ack", seen, 0);
    @(negedge clock);

    // Reset during the ACCESS cycle of a write.
    run("wr 0010", 0, 1, 16'h0010, 16'h1234, 0, 0, 16'h0000);
    w0 = wr_cnt;
    req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hFFFF;
    @(posedge clock);
    #1;
    check("abort in ACCESS wr_en", mem_wr_en, 1);
    check("abort in ACCESS addr", mem_address, 16'h0010);
    #1;
    reset = 1'b1;
    req0  = 1'b0;
    #1;
    check("abort wr_en dropped", mem_wr_en, 0);
    check("abort mem_address cleared", mem_address, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (ack0 || ack1 || err) seen = 1'b1;
    end
    check("abort no ack", seen, 0);
    check("abort no write", wr_cnt - w0, 0);
    check("abort mem intact", {mem[16], mem[17]}, 16'h1234);
    run("rd 0010 after abort", 0, 0, 16'h0010, 16'h0000, 0, 1, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
